i2c_reg_master: RTL and testbench

//  Single-master I2C engine for 8-bit register access to 7-bit-addressed slaves (e.g. TFP410 at 0x38).
//  One request = one register write (addr, reg, value) or one register read (addr, reg, Sr, addr+R, byte).

---
 rtl/i2c_reg_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// Single-master I2C engine: one 8-bit register write or read per request, open-drain SDA/SCL.
// Optional macro I2C_CLOCK_STRETCH_EN: bit timer freezes while a slave holds SCL low.
module i2c_reg_master (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  chip_addr,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  value,
    input  logic        enable,
    input  logic        is_read,
    input  logic [31:0] divider,
    inout  wire         sda,
    inout  wire         scl,
    output logic [7:0]  data,
    output logic        done,
    output logic        i2c_ack_error
);

    typedef enum logic [2:0] {
        IDLE, START, BYTE, ACK, RSTART, RBYTE, MACK, STOP
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q;
    logic [1:0]  idx_q;
    logic [7:0]  sh_q;
    logic [6:0]  ca_q;
    logic [7:0]  ra_q;
    logic [7:0]  val_q;
    logic        rd_q;
    logic [31:0] div_q;
    logic        sda_oe_q;
    logic        scl_oe_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  data_q;

    logic [7:0]  d0, d1, d2, d3;
    logic        stall;
    logic        at_d0, at_d1, at_d2, at_d3;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;
    assign scl = scl_oe_q ? 1'b0 : 1'bz;

    assign data          = data_q;
    assign done          = done_q;
    assign i2c_ack_error = err_q;

    always_comb begin
        d0 = div_q[7:0];
        d1 = div_q[15:8];
        d2 = div_q[23:16];
        d3 = div_q[31:24];
        stall = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
        // SCL released by us but still low: a slave is stretching the clock
        stall = (state_q != IDLE) && !scl_oe_q && (scl == 1'b0);
`endif
        at_d0 = !stall && (cnt_q == d0);
        at_d1 = !stall && (cnt_q == d1);
        at_d2 = !stall && (cnt_q == d2);
        at_d3 = !stall && (cnt_q == d3);
        if (stall)
            cnt_d = cnt_q;
        else if (cnt_q == d3)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            ca_q     <= '0;
            ra_q     <= '0;
            val_q    <= '0;
            rd_q     <= 1'b0;
            div_q    <= '0;
            sda_oe_q <= 1'b0;
            scl_oe_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (enable) begin
                ca_q    <= chip_addr;
                ra_q    <= reg_addr;
                val_q   <= value;
                rd_q    <= is_read;
                div_q   <= divider;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                state_q <= START;
            end
        end else begin
            cnt_q <= cnt_d;
            // SCL is high from d1 to d3 in every slot; START keeps it high from idle
            if (at_d1 && state_q != START)
                scl_oe_q <= 1'b0;
            if (at_d3 && state_q != STOP)
                scl_oe_q <= 1'b1;

            case (state_q)
                START: begin
                    if (at_d0)
                        sda_oe_q <= 1'b1;
                    if (at_d3) begin
                        sh_q    <= {ca_q, 1'b0};
                        idx_q   <= 2'd0;
                        bit_q   <= '0;
                        state_q <= BYTE;
                    end
                end
                RSTART: begin
                    if (at_d0)
                        sda_oe_q <= 1'b0;
                    if (at_d2)
                        sda_oe_q <= 1'b1;
                    if (at_d3) begin
                        sh_q    <= {ca_q, 1'b1};
                        idx_q   <= 2'd2;
                        bit_q   <= '0;
                        state_q <= BYTE;
                    end
                end
                BYTE: begin
                    if (at_d0)
                        sda_oe_q <= ~sh_q[7];
                    if (at_d3) begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_q <= ACK;
                    end
                end
                ACK: begin
                    if (at_d0)
                        sda_oe_q <= 1'b0;
                    if (at_d2 && sda == 1'b1)
                        err_q <= 1'b1;
                    if (at_d3) begin
                        if (err_q) begin
                            state_q <= STOP;
                        end else begin
                            case (idx_q)
                                2'd0: begin
                                    sh_q    <= ra_q;
                                    idx_q   <= 2'd1;
                                    state_q <= BYTE;
                                end
                                2'd1: begin
                                    if (rd_q) begin
                                        state_q <= RSTART;
                                    end else begin
                                        sh_q    <= val_q;
                                        idx_q   <= 2'd2;
                                        state_q <= BYTE;
                                    end
                                end
                                default: state_q <= rd_q ? RBYTE : STOP;
                            endcase
                        end
                    end
                end
                RBYTE: begin
                    if (at_d0)
                        sda_oe_q <= 1'b0;
                    if (at_d2)
                        sh_q <= {sh_q[6:0], sda};
                    if (at_d3) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            data_q  <= sh_q;
                            state_q <= MACK;
                        end
                    end
                end
                MACK: begin
                    if (at_d0)
                        sda_oe_q <= 1'b0;
                    if (at_d3)
                        state_q <= STOP;
                end
                STOP: begin
                    if (at_d0)
                        sda_oe_q <= 1'b1;
                    if (at_d2)
                        sda_oe_q <= 1'b0;
                    if (at_d3) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural I2C slave at 0x38 plus a queue-based scoreboard on done.
module tb_i2c_reg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  chip_addr;
    logic [7:0]  reg_addr;
    logic [7:0]  value;
    logic        enable;
    logic        is_read;
    logic [31:0] divider;
    wire         sda;
    wire         scl;
    logic [7:0]  data;
    logic        done;
    logic        i2c_ack_error;

    logic sl_sda_low = 1'b0;
    logic sl_scl_low = 1'b0;
    pullup (sda);
    pullup (scl);
    assign sda = sl_sda_low ? 1'b0 : 1'bz;
    assign scl = sl_scl_low ? 1'b0 : 1'bz;

    i2c_reg_master dut (
        .clk           (clk),
        .reset         (reset),
        .chip_addr     (chip_addr),
        .reg_addr      (reg_addr),
        .value         (value),
        .enable        (enable),
        .is_read       (is_read),
        .divider       (divider),
        .sda           (sda),
        .scl           (scl),
        .data          (data),
        .done          (done),
        .i2c_ack_error (i2c_ack_error)
    );

    localparam logic [31:0] DIV_STD  = 32'hC8966432;
    localparam logic [31:0] DIV_FAST = 32'h0F0B0703;
    localparam logic [6:0]  SL_ADDR  = 7'h38;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // ---------------- behavioural slave ----------------
    logic [7:0]  mem [0:255];
    int unsigned bitcnt = 0;
    int unsigned byte_idx = 0;
    logic [7:0]  shreg = '0;
    logic [7:0]  txbyte = '0;
    logic [7:0]  ptr = '0;
    logic        in_ack = 1'b0, sending = 1'b0, sel = 1'b0, rd_mode = 1'b0;
    logic [31:0] log_bytes = '0;
    int unsigned n_bytes = 0, n_starts = 0, n_stops = 0, n_rises = 0;
    logic        stretch_arm = 1'b0;

    always @(negedge sda) begin
        if (scl === 1'b1) begin
            n_starts++;
            bitcnt = 0; byte_idx = 0; in_ack = 1'b0;
            sending = 1'b0; sel = 1'b0; sl_sda_low = 1'b0;
        end
    end

    always @(posedge sda) begin
        if (scl === 1'b1) begin
            n_stops++;
            sel = 1'b0; sending = 1'b0;
        end
    end

    always @(posedge scl) begin
        n_rises++;
        if (!in_ack && bitcnt < 8) begin
            shreg = {shreg[6:0], sda};
            bitcnt++;
        end
    end

    always @(negedge scl) begin
        if (in_ack) begin
            in_ack = 1'b0; sl_sda_low = 1'b0; bitcnt = 0;
            if (sending) begin
                sending = 1'b0;
            end else if (sel && rd_mode && byte_idx == 1) begin
                sending = 1'b1;
                txbyte = mem[ptr];
                sl_sda_low = ~txbyte[7];
            end
        end else if (bitcnt == 8) begin
            in_ack = 1'b1;
            if (sending) begin
                sl_sda_low = 1'b0;
            end else begin
                log_bytes = {log_bytes[23:0], shreg};
                n_bytes++;
                if (byte_idx == 0) begin
                    sel = (shreg[7:1] == SL_ADDR);
                    rd_mode = shreg[0];
                end else if (sel && byte_idx == 1) begin
                    ptr = shreg;
                end else if (sel) begin
                    mem[ptr] = shreg;
                    ptr = ptr + 8'd1;
                end
                sl_sda_low = sel;
                byte_idx++;
            end
        end else if (sending) begin
            sl_sda_low = ~txbyte[7 - bitcnt];
        end
    end

    always @(negedge scl) begin
        if (stretch_arm) begin
            stretch_arm = 1'b0;
            sl_scl_low = 1'b1;
            repeat (500) @(posedge clk);
            sl_scl_low = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic        bus;
        logic [31:0] bytes;
        int unsigned nb, ns, np, nr;
    } exp_t;

    exp_t exp_q[$];
    logic mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [7:0] d, logic e, logic b, logic [31:0] by,
                                int unsigned nb, int unsigned ns, int unsigned np, int unsigned nr);
        exp_t x;
        x.data = d; x.err = e; x.bus = b; x.bytes = by;
        x.nb = nb; x.ns = ns; x.np = np; x.nr = nr;
        return x;
    endfunction

    initial begin
        logic done_prev;
        exp_t x;
        wait (mon_on);
        done_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk("data", {24'd0, data}, {24'd0, x.data});
                    chk("ack_error", {31'd0, i2c_ack_error}, {31'd0, x.err});
                    if (x.bus) begin
                        chk("bus_bytes", log_bytes, x.bytes);
                        chk("bus_nbytes", n_bytes, x.nb);
                        chk("bus_starts", n_starts, x.ns);
                        chk("bus_stops", n_stops, x.np);
                        chk("scl_rises", n_rises, x.nr);
                    end
                end
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_req(input logic rd, input logic [6:0] ca, input logic [7:0] ra,
                             input logic [7:0] v, input logic [31:0] dv);
        log_bytes = '0; n_bytes = 0; n_starts = 0; n_stops = 0; n_rises = 0;
        is_read = rd; chip_addr = ca; reg_addr = ra; value = v; divider = dv;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned cyc_base;
        logic busy_seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h09] = 8'h06;
        reset = 1'b0; enable = 1'b0; is_read = 1'b0;
        chip_addr = '0; reg_addr = '0; value = '0; divider = DIV_STD;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_ack_error", {31'd0, i2c_ack_error}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        chk("rst_scl", {31'd0, scl}, 32'd1);
        mon_on = 1'b1;
        @(posedge clk); #1;

        // write 0x38/0x08/0xBF at the standard bus rate
        exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 32'h007008BF, 3, 1, 1, 28));
        start_req(1'b0, 7'h38, 8'h08, 8'hBF, DIV_STD);
        chk("busy_after_enable", {31'd0, done}, 32'd0);
        wait_done(8000, cyc);

        // read 0x38/0x09 -> 0x06
        exp_q.push_back(mk(8'h06, 1'b0, 1'b1, 32'h00700971, 3, 2, 1, 38));
        start_req(1'b1, 7'h38, 8'h09, 8'h00, DIV_FAST);
        wait_done(2000, cyc_base);

        // read back the register written above
        exp_q.push_back(mk(8'hBF, 1'b0, 1'b1, 32'h00700871, 3, 2, 1, 38));
        start_req(1'b1, 7'h38, 8'h08, 8'h00, DIV_FAST);
        wait_done(2000, cyc);

        // enable pulsed mid-transaction with different inputs must be ignored
        exp_q.push_back(mk(8'hBF, 1'b0, 1'b1, 32'h0070105A, 3, 1, 1, 28));
        start_req(1'b0, 7'h38, 8'h10, 8'h5A, DIV_FAST);
        repeat (40) @(posedge clk);
        #1;
        chip_addr = 7'h11; is_read = 1'b1; reg_addr = 8'hEE; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        wait_done(2000, cyc);
        busy_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (!done) busy_seen = 1'b1;
        end
        chk("no_extra_transaction", {31'd0, busy_seen}, 32'd0);
        chk("slave_reg10", {24'd0, mem[8'h10]}, 32'h5A);

        // no slave at 0x22: NACK on address, data preserved
        exp_q.push_back(mk(8'hBF, 1'b1, 1'b1, 32'h00000044, 1, 1, 1, 10));
        start_req(1'b1, 7'h22, 8'h09, 8'h00, DIV_FAST);
        wait_done(2000, cyc);

        // next accepted request clears the error
        exp_q.push_back(mk(8'h06, 1'b0, 1'b1, 32'h00700971, 3, 2, 1, 38));
        start_req(1'b1, 7'h38, 8'h09, 8'h00, DIV_FAST);
        wait_done(2000, cyc);

        // reset in the middle of the address byte
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 32'h0, 0, 0, 0, 0));
        start_req(1'b0, 7'h38, 8'h08, 8'h33, DIV_FAST);
        repeat (53) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_sda", {31'd0, sda}, 32'd1);
        chk("midrst_scl", {31'd0, scl}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd1);
        chk("midrst_ack_error", {31'd0, i2c_ack_error}, 32'd0);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 32'h00700877, 3, 1, 1, 28));
        start_req(1'b0, 7'h38, 8'h08, 8'h77, DIV_FAST);
        wait_done(2000, cyc);

        exp_q.push_back(mk(8'h77, 1'b0, 1'b1, 32'h00700871, 3, 2, 1, 38));
        start_req(1'b1, 7'h38, 8'h08, 8'h00, DIV_FAST);
        wait_done(2000, cyc);

`ifdef I2C_CLOCK_STRETCH_EN
        exp_q.push_back(mk(8'h06, 1'b0, 1'b1, 32'h00700971, 3, 2, 1, 38));
        stretch_arm = 1'b1;
        start_req(1'b1, 7'h38, 8'h09, 8'h00, DIV_FAST);
        wait_done(3000, cyc);
        chk("stretch_extends", {31'd0, (cyc >= cyc_base + 400)}, 32'd1);
`endif

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
